sd_cmd_sequencer: RTL and testbench
===================================

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16'd4096: max SD_CLK_IN cycles from handshake accept to completion status.
REQ-002 Parameter WO_DELAY, default 3'd7: post-command delay for no-response commands, driven as SETTING_O[10:8].
REQ-003 Parameter SRST_LEN, default 3'd4: SD_CLK_IN cycles that srst_o is held after timeout.
REQ-004 SD_CLK_IN  in  1  clock; all logic rising-edge.
REQ-005 RST_IN  in  1  reset; asynchronous, active-high.
REQ-006 start_i  in  1  one-cycle command start pulse; ignored unless busy_o=0.
REQ-007 cmd_index_i  in  6  command index; arg_i  in  32  command argument.
REQ-008 rsp_type_i  in  2  00 none, 01 short (48-bit), 10 long (136-bit), 11 treated as 01.
REQ-009 crc_chk_i, idx_chk_i, blk_rd_i, blk_wr_i  in  1 each  CRC check, index check, data read follows, data write follows.
REQ-010 SETTING_O  out  16; CMD_O  out  40; REQ_O  out  1; ACK_O  out  1: request side to the command serial engine.
REQ-011 REQ_I  in  1; ACK_I  in  1; STATUS_I  in  8; CMD_I  in  128: engine status side (engine REQ_OUT, ACK_OUT, STATUS, CMD_OUT).
REQ-012 srst_o  out  1: engine soft reset; busy_o  out  1; done_o  out  1 one-cycle pulse; err_o  out  3 {index, crc, timeout}; rsp_o  out  128.

Function
REQ-013 States IDLE, LOAD, REQ, WAIT, FIN, RECOVER; one-hot or binary free.
REQ-014 IDLE: busy_o=0; start_i=1 -> LOAD, busy_o=1 next cycle, err_o cleared, inputs registered.
REQ-015 LOAD (1 cycle): CMD_O={2'b01, cmd_index_i, arg_i}; SETTING_O[6:0]=0/40/127 for none/short/long; [7]=crc_chk_i & (rsp_type!=00); [10:8]=WO_DELAY; [11]=blk_wr_i; [12]=blk_rd_i; [15:13]=0 -> REQ.
REQ-016 REQ: REQ_O=1, held until ACK_I=0 sampled; then REQ_O=0, timeout counter cleared -> WAIT.
REQ-017 SETTING_O and CMD_O SHALL stay stable from LOAD until FIN exit.
REQ-018 WAIT: each REQ_I rising edge with STATUS_I[6]=0 is intermediate status; ACK_O=1 until REQ_I=0 sampled, then 0.
REQ-019 WAIT: REQ_I=1 with STATUS_I[6]=1 is completion -> capture rsp_o=CMD_I, err_o[1]=crc_chk & ~STATUS_I[5] for responses, ACK_O=1 -> FIN.
REQ-020 Index check: rsp_type 01, idx_chk_i=1 and CMD_I[125:120]!=cmd_index -> err_o[2]=1; long responses never index-checked.
REQ-021 FIN: ACK_O held 1 until ACK_I=1 and REQ_I=0 both sampled; then ACK_O=0, done_o=1 for one cycle -> IDLE.
REQ-022 Timeout: 16-bit counter increments every cycle in WAIT/FIN, saturating; reaching TIMEOUT -> err_o[0]=1, REQ_O=ACK_O=0 -> RECOVER.
REQ-023 RECOVER: srst_o=1 for SRST_LEN cycles, then done_o pulse, -> IDLE; rsp_o not updated.
REQ-024 Completion and timeout in the same cycle: completion wins.
REQ-025 start_i while busy_o=1: ignored, no state or error change.
REQ-026 ACK_I=0 already when entering REQ: accept on first sampled cycle (REQ_O high at least 1 cycle).
REQ-027 err_o and rsp_o SHALL hold until next accepted start_i.

Reset
REQ-028 RST_IN=1 at any time, including mid-command: state IDLE, REQ_O=ACK_O=srst_o=busy_o=done_o=0, err_o=0, rsp_o=0, SETTING_O=0, CMD_O=0, counters 0.
REQ-029 First start_i accepted on the first rising edge after RST_IN deasserts.

Verification
REQ-030 Short cmd index 17, arg 32'h0000_0200, idx/crc check on; engine model returns CMD_I[125:120]=17, STATUS_I=8'h66 -> CMD_O=40'h51_0000_0200, SETTING_O[6:0]=40, err_o=0, one done_o.
REQ-031 No-response cmd 0 -> SETTING_O=16'h0700, completion STATUS_I=8'h44 -> err_o=0, done_o pulse.
REQ-032 Short response with STATUS_I[5]=0 and index mismatch (returned 5 vs sent 17) -> err_o=3'b110.
REQ-033 Engine never raises REQ_I -> after TIMEOUT cycles err_o=3'b001, srst_o high exactly SRST_LEN cycles, then done_o.
REQ-034 start_i during WAIT, then RST_IN pulse mid-WAIT -> second start ignored; after reset all outputs at REQ-028 values.
REQ-035 Long response (rsp_type 10) with 2 intermediate status REQ_I pulses -> each ACK_O'd, rsp_o=CMD_I at completion, SETTING_O[6:0]=127.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: drives one SD command through the command serial engine and collects its response
module sd_cmd_sequencer #(
   parameter logic [15:0] TIMEOUT  = 16'd4096,
   parameter logic [2:0]  WO_DELAY = 3'd7,
   parameter logic [2:0]  SRST_LEN = 3'd4
) (
   input  logic         SD_CLK_IN,
   input  logic         RST_IN,
   input  logic         start_i,
   input  logic [5:0]   cmd_index_i,
   input  logic [31:0]  arg_i,
   input  logic [1:0]   rsp_type_i,
   input  logic         crc_chk_i,
   input  logic         idx_chk_i,
   input  logic         blk_rd_i,
   input  logic         blk_wr_i,
   output logic [15:0]  SETTING_O,
   output logic [39:0]  CMD_O,
   output logic         REQ_O,
   output logic         ACK_O,
   input  logic         REQ_I,
   input  logic         ACK_I,
   input  logic [7:0]   STATUS_I,
   input  logic [127:0] CMD_I,
   output logic         srst_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [2:0]   err_o,
   output logic [127:0] rsp_o
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_REQ     = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_FIN     = 3'd4;
   localparam logic [2:0] S_RECOVER = 3'd5;

   logic [2:0]   r_state;
   logic [5:0]   r_idx;
   logic [31:0]  r_arg;
   logic [1:0]   r_rsp_type;
   logic         r_crc_chk;
   logic         r_idx_chk;
   logic         r_blk_rd;
   logic         r_blk_wr;
   logic [15:0]  r_setting;
   logic [39:0]  r_cmd;
   logic         r_req;
   logic         r_ack;
   logic [15:0]  r_cnt;
   logic [2:0]   r_scnt;
   logic         r_srst;
   logic         r_done;
   logic [2:0]   r_err;
   logic [127:0] r_rsp;

   logic [2:0]   w_state_nxt;
   logic         w_has_rsp;
   logic         w_long;
   logic         w_short;
   logic [6:0]   w_rsp_len;
   logic         w_complete;
   logic         w_fin_done;
   logic         w_timeout;
   logic         w_tmo;
   logic         w_accept;
   logic         w_req_acc;
   logic         w_wait_done;
   logic         w_fin_exit;
   logic         w_rec_end;
   logic         w_idx_err;
   logic         w_crc_err;
   logic         w_ack_nxt;
   logic [15:0]  w_cnt_inc;
   logic         w_unused;

   assign w_has_rsp   = r_rsp_type != 2'b00;
   assign w_long      = r_rsp_type == 2'b10;
   assign w_short     = w_has_rsp & ~w_long;
   assign w_rsp_len   = !w_has_rsp ? 7'd0 : w_long ? 7'd127 : 7'd40;
   assign w_complete  = REQ_I & STATUS_I[6];
   assign w_fin_done  = ACK_I & ~REQ_I;
   assign w_timeout   = r_cnt >= TIMEOUT - 16'd1;
   assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   assign w_accept    = (r_state == S_IDLE) & start_i;
   assign w_req_acc   = (r_state == S_REQ) & ~ACK_I;
   assign w_wait_done = (r_state == S_WAIT) & w_complete;
   assign w_fin_exit  = (r_state == S_FIN) & w_fin_done;
   // completion is checked first so it wins over a simultaneous timeout
   assign w_tmo       = (((r_state == S_WAIT) & ~w_complete) | ((r_state == S_FIN) & ~w_fin_done)) & w_timeout;
   assign w_rec_end   = (r_state == S_RECOVER) & (r_scnt == SRST_LEN - 3'd1);
   // long responses carry no index field, so only short ones are index-checked
   assign w_idx_err   = w_short & r_idx_chk & (CMD_I[125:120] != r_idx);
   assign w_crc_err   = w_has_rsp & r_crc_chk & ~STATUS_I[5];
   assign w_ack_nxt   = (r_state == S_WAIT) ? (w_complete | (REQ_I & ~w_timeout)) :
                        (r_state == S_FIN)  ? (~w_fin_done & ~w_timeout) : 1'b0;
   assign w_unused    = ^{STATUS_I[7], STATUS_I[4:0]};

   // next-state selection for the command sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    w_state_nxt = start_i ? S_LOAD : S_IDLE;
         S_LOAD:    w_state_nxt = S_REQ;
         S_REQ:     w_state_nxt = ACK_I ? S_REQ : S_WAIT;
         S_WAIT:    w_state_nxt = w_complete ? S_FIN : w_timeout ? S_RECOVER : S_WAIT;
         S_FIN:     w_state_nxt = w_fin_done ? S_IDLE : w_timeout ? S_RECOVER : S_FIN;
         S_RECOVER: w_state_nxt = w_rec_end ? S_IDLE : S_RECOVER;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // latch the request on accept and build the engine command/settings in LOAD
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_idx      <= '0;
         r_arg      <= '0;
         r_rsp_type <= '0;
         r_crc_chk  <= 1'b0;
         r_idx_chk  <= 1'b0;
         r_blk_rd   <= 1'b0;
         r_blk_wr   <= 1'b0;
         r_cmd      <= '0;
         r_setting  <= '0;
      end else if (w_accept) begin
         r_idx      <= cmd_index_i;
         r_arg      <= arg_i;
         r_rsp_type <= rsp_type_i;
         r_crc_chk  <= crc_chk_i;
         r_idx_chk  <= idx_chk_i;
         r_blk_rd   <= blk_rd_i;
         r_blk_wr   <= blk_wr_i;
      end else if (r_state == S_LOAD) begin
         r_cmd      <= {2'b01, r_idx, r_arg};
         r_setting  <= {3'b000, r_blk_rd, r_blk_wr, WO_DELAY, r_crc_chk & w_has_rsp, w_rsp_len};
      end
   end

   // request/acknowledge handshakes with the engine
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_req <= 1'b0;
         r_ack <= 1'b0;
      end else begin
         r_req <= (r_state == S_LOAD) | ((r_state == S_REQ) & ACK_I);
         r_ack <= w_ack_nxt;
      end
   end

   // response timeout counter and soft-reset stretch
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_cnt  <= '0;
         r_scnt <= '0;
         r_srst <= 1'b0;
      end else begin
         r_cnt  <= w_req_acc ? 16'd0 : ((r_state == S_WAIT) | (r_state == S_FIN)) ? w_cnt_inc : r_cnt;
         r_scnt <= (r_state == S_RECOVER) ? r_scnt + 3'd1 : 3'd0;
         r_srst <= w_tmo | ((r_state == S_RECOVER) & ~w_rec_end);
      end
   end

   // completion status, captured response and done pulse
   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         r_err  <= '0;
         r_rsp  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_fin_exit | w_rec_end;
         if (w_accept)
            r_err <= 3'b000;
         else if (w_wait_done)
            r_err <= {w_idx_err, w_crc_err, 1'b0};
         else if (w_tmo)
            r_err <= r_err | 3'b001;
         if (w_wait_done)
            r_rsp <= CMD_I;
      end
   end

   assign SETTING_O = r_setting;
   assign CMD_O     = r_cmd;
   assign REQ_O     = r_req;
   assign ACK_O     = r_ack;
   assign srst_o    = r_srst;
   assign busy_o    = r_state != S_IDLE;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign rsp_o     = r_rsp;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: randomized scoreboard bench for sd_cmd_sequencer with an engine model
module tb_sd_cmd_sequencer;
   localparam logic [15:0] TB_TIMEOUT = 16'd200;
   localparam logic [2:0]  TB_WO      = 3'd7;
   localparam logic [2:0]  TB_SRST    = 3'd4;
   localparam int W_REQ1 = 0, W_REQ0 = 1, W_ACK1 = 2, W_ACK0 = 3;

   logic         SD_CLK_IN = 1'b0;
   logic         RST_IN = 1'b1;
   logic         start_i = 1'b0;
   logic [5:0]   cmd_index_i = '0;
   logic [31:0]  arg_i = '0;
   logic [1:0]   rsp_type_i = '0;
   logic         crc_chk_i = 1'b0, idx_chk_i = 1'b0, blk_rd_i = 1'b0, blk_wr_i = 1'b0;
   logic [15:0]  SETTING_O;
   logic [39:0]  CMD_O;
   logic         REQ_O, ACK_O;
   logic         REQ_I = 1'b0, ACK_I = 1'b0;
   logic [7:0]   STATUS_I = '0;
   logic [127:0] CMD_I = '0;
   logic         srst_o, busy_o, done_o;
   logic [2:0]   err_o;
   logic [127:0] rsp_o;

   typedef struct packed {
      logic [2:0]   err;
      logic [127:0] rsp;
      logic [15:0]  set;
      logic [39:0]  cmd;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [127:0] last_rsp = '0;
   logic         prev_done = 1'b0;
   int           n_chk = 0;
   int           n_pass = 0;

   sd_cmd_sequencer #(.TIMEOUT(TB_TIMEOUT), .WO_DELAY(TB_WO), .SRST_LEN(TB_SRST)) dut (
      .SD_CLK_IN(SD_CLK_IN), .RST_IN(RST_IN), .start_i(start_i), .cmd_index_i(cmd_index_i),
      .arg_i(arg_i), .rsp_type_i(rsp_type_i), .crc_chk_i(crc_chk_i), .idx_chk_i(idx_chk_i),
      .blk_rd_i(blk_rd_i), .blk_wr_i(blk_wr_i), .SETTING_O(SETTING_O), .CMD_O(CMD_O),
      .REQ_O(REQ_O), .ACK_O(ACK_O), .REQ_I(REQ_I), .ACK_I(ACK_I), .STATUS_I(STATUS_I),
      .CMD_I(CMD_I), .srst_o(srst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .rsp_o(rsp_o)
   );

   always #5 SD_CLK_IN = ~SD_CLK_IN;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         W_REQ1:  return REQ_O === 1'b1;
         W_REQ0:  return REQ_O === 1'b0;
         W_ACK1:  return ACK_O === 1'b1;
         W_ACK0:  return ACK_O === 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_until(input int sel, input string nm);
      int n = 0;
      do begin
         @(negedge SD_CLK_IN);
         n++;
      end while (!cond(sel) && n < 400);
      if (!cond(sel)) begin
         n_chk++;
         $display("FAIL wait_%s: condition not reached within %0d cycles, required within 400", nm, n);
      end
   endtask

   // expected outcome straight from the command rules
   function automatic exp_t model(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                                  input logic crc, input logic ichk, input logic rd, input logic wr,
                                  input logic [7:0] st, input logic [127:0] resp, input bit tmo);
      exp_t e;
      int   len;
      len = (rt == 2'd0) ? 0 : (rt == 2'd2) ? 127 : 40;
      e.cmd = {2'b01, idx, arg};
      e.set = {3'b000, rd, wr, TB_WO, crc && rt != 2'd0, 7'(len)};
      if (tmo) begin
         e.err = 3'b001;
         e.rsp = last_rsp;
      end else begin
         e.err = {(rt == 2'd1 || rt == 2'd3) && ichk && resp[125:120] != idx, rt != 2'd0 && crc && !st[5], 1'b0};
         e.rsp = resp;
         last_rsp = resp;
      end
      return e;
   endfunction

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input logic crc, input logic ichk, input logic rd, input logic wr,
                          input int hold, input int ninter, input logic [7:0] st,
                          input logic [127:0] resp, input bit tmo);
      exp_t e;
      int   c;
      e = model(idx, arg, rt, crc, ichk, rd, wr, st, resp, tmo);
      sb.push_back(e);
      cmd_index_i = idx; arg_i = arg; rsp_type_i = rt;
      crc_chk_i = crc; idx_chk_i = ichk; blk_rd_i = rd; blk_wr_i = wr;
      REQ_I = 1'b0; ACK_I = (hold > 0); start_i = 1'b1;
      @(negedge SD_CLK_IN);
      start_i = 1'b0;
      cmd_index_i = 6'($urandom); arg_i = $urandom; rsp_type_i = 2'($urandom);
      chk("busy_after_start", busy_o, 1);
      wait_until(W_REQ1, "req_hi");
      repeat (hold) @(negedge SD_CLK_IN);
      ACK_I = 1'b0;
      wait_until(W_REQ0, "req_lo");
      chk("cmd_o", CMD_O, e.cmd);
      chk("setting_o", SETTING_O, e.set);
      if (tmo) begin
         c = 0;
         while (srst_o !== 1'b1 && c < int'(TB_TIMEOUT) + 20) begin
            @(negedge SD_CLK_IN);
            c++;
         end
         chk("timeout_cycles", c, TB_TIMEOUT);
         chk("recover_req_ack", {REQ_O, ACK_O}, 2'b00);
         c = 0;
         while (srst_o === 1'b1 && c < 20) begin
            @(negedge SD_CLK_IN);
            c++;
         end
         chk("srst_len", c, TB_SRST);
      end else begin
         for (int i = 0; i < ninter; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge SD_CLK_IN);
            REQ_I = 1'b1;
            STATUS_I = 8'($urandom) & 8'hBF;
            CMD_I = {$urandom, $urandom, $urandom, $urandom};
            wait_until(W_ACK1, "inter_ack_hi");
            REQ_I = 1'b0;
            wait_until(W_ACK0, "inter_ack_lo");
            chk("inter_busy", busy_o, 1);
         end
         repeat ($urandom_range(1, 4)) @(negedge SD_CLK_IN);
         REQ_I = 1'b1; STATUS_I = st; CMD_I = resp;
         wait_until(W_ACK1, "fin_ack_hi");
         REQ_I = 1'b0; STATUS_I = '0; CMD_I = {$urandom, $urandom, $urandom, $urandom};
         repeat ($urandom_range(0, 2)) @(negedge SD_CLK_IN);
         chk("fin_ack_held", ACK_O, 1);
         ACK_I = 1'b1;
         wait_until(W_ACK0, "fin_ack_lo");
         ACK_I = 1'b0;
      end
   endtask

   // monitor: every done pulse retires one scoreboard entry
   always @(negedge SD_CLK_IN) begin
      if (!RST_IN && done_o) begin
         chk("done_single", prev_done, 0);
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL done_unexpected: got done pulse, required none pending");
         end else begin
            mon_e = sb.pop_front();
            chk("err_o", err_o, mon_e.err);
            chk("rsp_o", rsp_o, mon_e.rsp);
            chk("done_setting", SETTING_O, mon_e.set);
            chk("done_busy", busy_o, 0);
         end
      end
      prev_done <= done_o;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  r;
      logic [5:0]   idx;
      logic [1:0]   rt;
      logic [127:0] resp;
      repeat (2) @(negedge SD_CLK_IN);
      chk("rst_busy", busy_o, 0);
      chk("rst_outs", {REQ_O, ACK_O, srst_o, done_o, err_o}, 0);
      chk("rst_cmd_set", {CMD_O, SETTING_O}, 0);
      RST_IN = 1'b0;
      resp = {$urandom, $urandom, $urandom, $urandom};
      resp[125:120] = 6'd17;
      run_cmd(6'd17, 32'h0000_0200, 2'b01, 1, 1, 0, 0, 0, 0, 8'h66, resp, 0);
      run_cmd(6'd0, 32'h0, 2'b00, 1, 0, 0, 0, 2, 0, 8'h44, {$urandom, $urandom, $urandom, $urandom}, 0);
      resp[125:120] = 6'd5;
      run_cmd(6'd17, 32'h1234_5678, 2'b01, 1, 1, 0, 0, 1, 0, 8'h44, resp, 0);
      run_cmd(6'd2, 32'h0, 2'b10, 1, 1, 0, 0, 0, 2, 8'h60, {$urandom, $urandom, $urandom, $urandom}, 0);
      run_cmd(6'd13, 32'hDEAD_BEEF, 2'b01, 1, 1, 0, 0, 0, 0, 8'h60, '0, 1);
      run_cmd(6'd18, 32'h55, 2'b11, 0, 1, 1, 0, 3, 1, 8'hC0, resp, 0);
      // abort a command mid-response with a stray start and a reset
      cmd_index_i = 6'd9; arg_i = 32'hA5A5_0009; rsp_type_i = 2'b01; ACK_I = 1'b0; start_i = 1'b1;
      @(negedge SD_CLK_IN);
      start_i = 1'b0;
      wait_until(W_REQ1, "abort_req_hi");
      wait_until(W_REQ0, "abort_req_lo");
      repeat (3) @(negedge SD_CLK_IN);
      cmd_index_i = 6'd33; arg_i = 32'h0; start_i = 1'b1;
      @(negedge SD_CLK_IN);
      start_i = 1'b0;
      @(negedge SD_CLK_IN);
      chk("ignored_start_cmd", CMD_O, {2'b01, 6'd9, 32'hA5A5_0009});
      chk("ignored_start_busy", busy_o, 1);
      chk("ignored_start_err", err_o, 0);
      RST_IN = 1'b1;
      #1;
      chk("midrst_outs", {REQ_O, ACK_O, srst_o, busy_o, done_o, err_o}, 0);
      chk("midrst_rsp", rsp_o, 0);
      chk("midrst_cmd_set", {CMD_O, SETTING_O}, 0);
      last_rsp = '0;
      @(negedge SD_CLK_IN);
      RST_IN = 1'b0;
      run_cmd(6'd7, 32'h0000_0777, 2'b01, 1, 0, 0, 1, 0, 0, 8'h40, {$urandom, $urandom, $urandom, $urandom}, 0);
      for (int k = 0; k < 24; k++) begin
         idx = 6'($urandom);
         rt = 2'($urandom);
         r = $urandom;
         resp = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 1) == 1) resp[125:120] = idx;
         run_cmd(idx, $urandom, rt, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 2), r[7:0] | 8'h40, resp,
                 $urandom_range(0, 7) == 0);
      end
      repeat (5) @(negedge SD_CLK_IN);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
